// File: rtl/dmem_pkg.sv
// Shared types and big-endian lane helpers for the data-memory arbiter.
package dmem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Lane 0 is the most significant byte of the word.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input size_e       size,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      BYTE:    r = {{24{sgn & b[7]}}, b};
      HALF:    r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input size_e       size,
                                             input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    case (size)
      BYTE: begin
        case (off)
          2'd0:    r[31:24] = wdata[7:0];
          2'd1:    r[23:16] = wdata[7:0];
          2'd2:    r[15:8]  = wdata[7:0];
          default: r[7:0]   = wdata[7:0];
        endcase
      end
      HALF: begin
        if (off[1]) r[15:0]  = wdata[15:0];
        else        r[31:16] = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter/sequencer for the single-port dmem; sub-word stores use RMW.
// Latency from grant: error 1, load 2, word store 2, sub-word store 3; no new grant until back in IDLE.
import dmem_pkg::*;

module dmem_arbiter #(
  parameter int WORDS = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_we,
  input  logic [1:0][1:0]  req_size,
  input  logic [1:0]       req_signed,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_wdata,
  output logic [1:0]       rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             mem_we,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd
);

  localparam logic [29:0] WORD_LIMIT = 30'(WORDS);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  size_e       size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic        err_q, err_d;

  logic        gnt;
  logic [1:0]  gnt_size;
  logic [31:0] gnt_addr;
  logic        gnt_err;

  // On a tie, favour whichever requester was not served last.
  always_comb begin
    gnt      = (&req_valid) ? ~last_grant_q : req_valid[1];
    gnt_size = req_size[gnt];
    gnt_addr = req_addr[gnt];
    gnt_err  = (gnt_size == 2'd3)
             | ((gnt_size == 2'd1) & gnt_addr[0])
             | ((gnt_size == 2'd2) & (|gnt_addr[1:0]))
             | (gnt_addr[31:2] >= WORD_LIMIT);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    size_d       = size_q;
    signed_d     = signed_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    word_d       = word_q;
    err_d        = err_q;
    req_ready    = '0;
    rsp_valid    = '0;
    rsp_err      = 1'b0;
    rsp_rdata    = '0;
    mem_we       = 1'b0;
    mem_a        = '0;
    mem_wd       = '0;

    case (state_q)
      IDLE: begin
        if (!reset && (|req_valid)) begin
          req_ready[gnt] = 1'b1;
          last_grant_d   = gnt;
          owner_d        = gnt;
          we_d           = req_we[gnt];
          size_d         = gnt_err ? WORD : size_e'(gnt_size);
          signed_d       = req_signed[gnt];
          addr_d         = gnt_addr;
          wdata_d        = req_wdata[gnt];
          err_d          = gnt_err;
          if (gnt_err)                               state_d = RESP;
          else if (req_we[gnt] && gnt_size == 2'd2)  state_d = WRITE;
          else                                       state_d = READ;
        end
      end
      READ: begin
        mem_a   = {addr_q[31:2], 2'b00};
        word_d  = mem_rd;
        state_d = we_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_we  = !reset;
        mem_a   = {addr_q[31:2], 2'b00};
        mem_wd  = lane_merge(word_q, addr_q[1:0], size_q, wdata_q);
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        rsp_err            = err_q;
        if (!err_q && !we_q)
          rsp_rdata = lane_extract(word_q, addr_q[1:0], size_q, signed_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= WORD;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      word_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      word_q       <= word_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural single-port dmem.
module tb_dmem_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_we;
  logic [1:0][1:0]  req_size;
  logic [1:0]       req_signed;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic             mem_we;
  logic [31:0]      mem_a;
  logic [31:0]      mem_wd;
  logic [31:0]      mem_rd;

  dmem_arbiter #(.WORDS(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Behavioural dmem plus a backdoor preload port.
  logic [31:0] mem [64];
  logic        clr, pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_dat;
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (pl_en) begin
      mem[pl_idx] <= pl_dat;
    end else if (mem_we) begin
      mem[mem_a[7:2]] <= mem_wd;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model
  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
           || (a[31:2] >= 30'd64);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic sgn);
    int sh;
    logic [31:0] v;
    if (sz == 2'd0) begin
      sh = 8 * (3 - int'(a[1:0]));
      v  = (w >> sh) & 32'h0000_00FF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      sh = a[1] ? 0 : 16;
      v  = (w >> sh) & 32'h0000_FFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] a,
                                              input logic [1:0] sz, input logic [31:0] d);
    int sh;
    logic [31:0] m;
    if (sz == 2'd0) begin
      sh = 8 * (3 - int'(a[1:0]));
      m  = 32'h0000_00FF << sh;
      return (w & ~m) | ((d & 32'h0000_00FF) << sh);
    end else if (sz == 2'd1) begin
      sh = a[1] ? 0 : 16;
      m  = 32'h0000_FFFF << sh;
      return (w & ~m) | ((d & 32'h0000_FFFF) << sh);
    end
    return d;
  endfunction

  typedef struct {
    int          owner;
    logic        err;
    logic [31:0] rdata;
    int          due;
    logic        st;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  int          gq[$];
  logic [31:0] ref_mem [64];
  int          cyc = 0;
  int          both_cnt = 0;
  int          we_cnt = 0;
  int          we_cyc = 0;
  int          hs_cyc = 0;
  logic [31:0] last_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: predicts at each handshake, compares at each response.
  always @(negedge clk) begin
    exp_t e;
    int   p;
    int   lat;
    if (clr) for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    if (pl_en) ref_mem[pl_idx] = pl_dat;
    if (mem_we) begin
      we_cnt++;
      we_cyc = cyc;
    end
    if (req_ready == 2'b11) both_cnt++;
    if (reset) begin
      sb.delete();
    end else begin
      if (rsp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_owner", 32'(rsp_valid), (e.owner == 1) ? 32'd2 : 32'd1);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_latency", cyc, e.due);
          check("rsp_mem_a_idle", mem_a | mem_wd, 32'd0);
          last_rdata = rsp_rdata;
          if (e.st && !e.err) ref_mem[e.addr[7:2]] = model_store(ref_mem[e.addr[7:2]], e.addr, e.size, e.wdata);
        end
      end
      if (req_ready != 2'b00) begin
        p = req_ready[1] ? 1 : 0;
        gq.push_back(p);
        hs_cyc  = cyc;
        e.owner = p;
        e.st    = req_we[p];
        e.addr  = req_addr[p];
        e.size  = req_size[p];
        e.wdata = req_wdata[p];
        e.err   = model_err(e.size, e.addr);
        e.rdata = (e.err || e.st) ? 32'd0
                  : model_load(ref_mem[e.addr[7:2]], e.addr, e.size, req_signed[p]);
        if (e.err)                   lat = 1;
        else if (!e.st)              lat = 2;
        else if (e.size == 2'd2)     lat = 2;
        else                         lat = 3;
        e.due = cyc + lat;
        sb.push_back(e);
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_req(input int p, input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] a, input logic [31:0] d);
    logic ok;
    @(posedge clk); #1;
    req_we[p] = we; req_size[p] = sz; req_signed[p] = sgn;
    req_addr[p] = a; req_wdata[p] = d; req_valid[p] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[p]) ok = 1'b1;
    end
    check("handshake", 32'(ok), 32'd1);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    wait_drain();
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = 6'(idx); pl_dat = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_a"}, mem_a, 32'd0);
    check({tag, "_mem_wd"}, mem_wd, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    int g0;
    int exp_order [4];
    logic ok;
    reset = 1'b1; clr = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_dat = '0;
    req_valid = '0; req_we = '0; req_size = '0; req_signed = '0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1; clr = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1; reset = 1'b0;

    // Word store then load
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    check("word_store_mem", mem[4], 32'hDEAD_BEEF);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("word_load_lit", last_rdata, 32'hDEAD_BEEF);

    // Byte read-modify-write
    preload(4, 32'h1122_3344);
    c0 = we_cnt;
    do_req(0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AA);
    check("rmw_mem", mem[4], 32'h11AA_3344);
    check("rmw_we_count", 32'(we_cnt - c0), 32'd1);
    check("rmw_we_cycle", 32'(we_cyc - hs_cyc), 32'd2);

    // Half loads from requester 1
    preload(4, 32'h8001_7FFF);
    do_req(1, 1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
    check("shalf_lit", last_rdata, 32'hFFFF_8001);
    do_req(1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    check("uhalf_lit", last_rdata, 32'h0000_7FFF);
    do_req(0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_BEEF);
    check("half_store_mem", mem[8], 32'h0000_BEEF);

    // Error cases: misaligned, out of range, illegal size
    c0 = we_cnt;
    do_req(1, 1'b0, 2'd1, 1'b0, 32'h13, 32'h0);
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h102, 32'h5555_5555);
    do_req(0, 1'b1, 2'd3, 1'b0, 32'h10, 32'h5555_5555);
    check("err_no_write", 32'(we_cnt - c0), 32'd0);
    check("err_mem4", mem[4], 32'h8001_7FFF);

    // Reset asserted during the WRITE cycle of a byte store
    preload(8, 32'hCAFE_F00D);
    c0 = we_cnt;
    @(posedge clk); #1;
    req_we[0] = 1'b1; req_size[0] = 2'd0; req_signed[0] = 1'b0;
    req_addr[0] = 32'h21; req_wdata[0] = 32'h22; req_valid[0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[0]) ok = 1'b1;
    end
    check("rst_handshake", 32'(ok), 32'd1);
    @(posedge clk); #1; req_valid[0] = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    check("rst_mem_we_gated", 32'(mem_we), 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");
    check("rst_mem_unchanged", mem[8], 32'hCAFE_F00D);
    check("rst_no_write", 32'(we_cnt - c0), 32'd0);
    repeat (4) @(negedge clk);

    // Contention: both requesters hold loads; first tie after reset goes to 0
    @(posedge clk); #1;
    g0 = gq.size();
    req_we = 2'b00;
    req_size[0] = 2'd2; req_signed[0] = 1'b0; req_addr[0] = 32'h10;
    req_size[1] = 2'd0; req_signed[1] = 1'b1; req_addr[1] = 32'h10;
    req_valid = 2'b11;
    for (int i = 0; i < 40 && gq.size() < g0 + 4; i++) @(negedge clk);
    check("cont_grant_count", 32'(gq.size() - g0), 32'd4);
    @(posedge clk); #1; req_valid = 2'b00;
    wait_drain();
    exp_order = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      if (gq.size() > g0 + i) check($sformatf("cont_grant_%0d", i), 32'(gq[g0 + i]), 32'(exp_order[i]));
    end
    check("cont_never_both_ready", 32'(both_cnt), 32'd0);
    check("final_mem4", mem[4], ref_mem[4]);
    check("final_mem8", mem[8], ref_mem[8]);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
